// File: rtl/gate_pkg.sv
// Purpose: shared types for the gate_accum block (operation modes, FSM states).
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package gate_pkg;

  // Encoding matches the 2-bit mode input port directly.
  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // NAND accumulates as AND; the inversion is applied once, when the result
  // is published, so the reduction and accumulation only ever see the base op.
  function automatic mode_t base_op(mode_t m);
    return (m == MODE_NAND) ? MODE_AND : m;
  endfunction

  // True when the published result must be bitwise inverted.
  function automatic logic is_inverting(mode_t m);
    return (m == MODE_NAND);
  endfunction

endpackage

// File: rtl/gate_reduce.sv
// Purpose: combinational bitwise reduction of NCH operand channels with one base op.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   op  in  mode_t        operation; NAND is reduced as AND (inversion done by caller)
//   A   in  NCH*WIDTH     operand channels, channel k at [k*WIDTH +: WIDTH]
//   f   out WIDTH         reduction of all channels
module gate_reduce
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  mode_t                  op,
  input  logic [NCH*WIDTH-1:0]   A,
  output logic [WIDTH-1:0]       f
);

  mode_t eff_op;

  assign eff_op = base_op(op);

  // Channel 0 seeds the fold, so NCH=1 passes channel 0 straight through.
  always_comb begin
    f = A[WIDTH-1:0];
    for (int k = 1; k < NCH; k++) begin
      case (eff_op)
        MODE_OR:  f = f | A[k*WIDTH +: WIDTH];
        MODE_XOR: f = f ^ A[k*WIDTH +: WIDTH];
        default:  f = f & A[k*WIDTH +: WIDTH];
      endcase
    end
  end

endmodule

// File: rtl/gate_accum.sv
// Purpose: folds len samples of NCH-channel bitwise reductions into one result Q.
// Latency: q_valid rises the cycle after the final sample is accepted.
// Backpressure: in_ready drops while a result waits in DONE; held until q_ready.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   mode, len     operation and samples-per-result, latched on the first sample
//   in_valid/in_ready/A   sample handshake and operand channels
//   Q/q_valid/q_ready     result handshake
//   count         samples accepted in the current transaction
module gate_accum
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [LEN_W-1:0]      len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*WIDTH-1:0]  A,
  output logic [WIDTH-1:0]      Q,
  output logic                  q_valid,
  input  logic                  q_ready,
  output logic [LEN_W-1:0]      count
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state_q,  state_d;
  mode_t            mode_q,   mode_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] q_q,      q_d;
  logic [LEN_W-1:0] count_q,  count_d;
  logic [LEN_W-1:0] target_q, target_d;

  mode_t            red_op;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] acc_next;
  logic             accept;

  // The first sample must be reduced with the live mode input because
  // nothing has been latched yet; later samples use the latched mode so
  // mid-transaction mode changes have no effect.
  assign red_op = (state_q == ST_IDLE) ? mode_t'(mode) : mode_q;

  gate_reduce #(
    .WIDTH (WIDTH),
    .NCH   (NCH)
  ) u_reduce (
    .op (red_op),
    .A  (A),
    .f  (f)
  );

  function automatic logic [WIDTH-1:0] combine(mode_t op,
                                               logic [WIDTH-1:0] x,
                                               logic [WIDTH-1:0] y);
    case (base_op(op))
      MODE_OR:  return x | y;
      MODE_XOR: return x ^ y;
      default:  return x & y;
    endcase
  endfunction

  assign accept   = in_valid && (state_q != ST_DONE);
  assign acc_next = combine(mode_q, acc_q, f);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    q_d      = q_q;
    count_d  = count_q;
    target_d = target_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d   = mode_t'(mode);
          target_d = (len == '0) ? ONE : len;
          acc_d    = f;
          count_d  = ONE;
          if (target_d == ONE) begin
            state_d = ST_DONE;
            q_d     = is_inverting(mode_d) ? ~f : f;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end

      ST_ACCUM: begin
        if (accept) begin
          acc_d   = acc_next;
          // target never exceeds 2^LEN_W-1, so this increment cannot wrap.
          count_d = count_q + ONE;
          if (count_d == target_q) begin
            state_d = ST_DONE;
            q_d     = is_inverting(mode_q) ? ~acc_next : acc_next;
          end
        end
      end

      ST_DONE: begin
        // Q is deliberately left alone here: it stays visible in IDLE
        // until the next transaction publishes a new result.
        if (q_ready) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_AND;
      acc_q    <= '0;
      q_q      <= '0;
      count_q  <= '0;
      target_q <= ONE;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      count_q  <= count_d;
      target_q <= target_d;
    end
  end

  // Outputs are decoded straight from flops, so they are glitch-free.
  assign in_ready = (state_q != ST_DONE);
  assign q_valid  = (state_q == ST_DONE);
  assign Q        = q_q;
  assign count    = count_q;

endmodule

// File: tb/tb_gate_accum.sv
// Purpose: self-checking bench for gate_accum (WIDTH=4, NCH=2, LEN_W=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_gate_accum;

  localparam int WIDTH = 4;
  localparam int NCH   = 2;
  localparam int LEN_W = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           mode;
  logic [LEN_W-1:0]     len;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIDTH-1:0] A;
  logic [WIDTH-1:0]     Q;
  logic                 q_valid;
  logic                 q_ready;
  logic [LEN_W-1:0]     count;

  int n_checks = 0;
  int n_fail   = 0;

  gate_accum #(.WIDTH(WIDTH), .NCH(NCH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .Q        (Q),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [3:0] l, input logic [7:0] a);
    mode     = m;
    len      = l;
    A        = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
  endtask

  // Reference: the result is the base-op fold of every channel of every
  // sample in the transaction, inverted at the end for NAND.
  function automatic logic [3:0] ref_result(input logic [1:0] m, input logic [7:0] s[$]);
    logic [3:0] r;
    logic [3:0] vals[$];
    foreach (s[i]) begin
      vals.push_back(s[i][3:0]);
      vals.push_back(s[i][7:4]);
    end
    r = vals[0];
    for (int i = 1; i < vals.size(); i++) begin
      if (m == 2'b01)      r = r | vals[i];
      else if (m == 2'b10) r = r ^ vals[i];
      else                 r = r & vals[i];
    end
    return (m == 2'b11) ? ~r : r;
  endfunction

  initial begin
    logic [3:0] q_hold;

    vecs[0] = '{2'b00, 8'b1111_0101, 4'b0101};
    vecs[1] = '{2'b01, 8'b1001_0110, 4'b1111};
    vecs[2] = '{2'b10, 8'b1111_1010, 4'b0101};
    vecs[3] = '{2'b11, 8'b1100_1010, 4'b0111};
    vecs[4] = '{2'b00, 8'b0000_1111, 4'b0000};
    vecs[5] = '{2'b10, 8'b1001_1001, 4'b0000};
    vecs[6] = '{2'b11, 8'b0000_0000, 4'b1111};
    vecs[7] = '{2'b01, 8'b0000_0000, 4'b0000};

    rst = 1'b1; mode = 2'b00; len = '0; in_valid = 1'b0; A = '0; q_ready = 1'b0;

    // Reset state (reset held two cycles).
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_q", Q, 4'b0000);
    check("rst_qvalid", q_valid, 1'b0);
    check("rst_inready", in_ready, 1'b1);
    check("rst_count", count, 0);

    // AND len=1 with a long stall on the consumer side.
    send(2'b00, 4'd1, {4'b1100, 4'b1010});
    check("and1_qvalid", q_valid, 1'b1);
    check("and1_q", Q, 4'b1000);
    check("and1_count", count, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_q", Q, 4'b1000);
      check("stall_inready", in_ready, 1'b0);
    end
    pop();
    check("pop_qvalid", q_valid, 1'b0);
    check("pop_count", count, 0);
    check("pop_inready", in_ready, 1'b1);
    check("idle_q_retained", Q, 4'b1000);

    // OR len=3 with idle gaps; mode/len changes after the first sample ignored.
    send(2'b01, 4'd3, {4'b0000, 4'b0001});
    check("or3_count1", count, 1);
    tick();
    send(2'b00, 4'd1, {4'b0000, 4'b0010});
    check("or3_count2", count, 2);
    check("or3_qvalid2", q_valid, 1'b0);
    tick();
    send(2'b10, 4'd7, {4'b1000, 4'b0000});
    check("or3_qvalid", q_valid, 1'b1);
    check("or3_q", Q, 4'b1011);
    check("or3_count", count, 3);
    pop();

    // NAND len=2.
    send(2'b11, 4'd2, {4'b1110, 4'b1111});
    send(2'b11, 4'd2, {4'b0111, 4'b1111});
    check("nand2_q", Q, 4'b1001);
    check("nand2_qvalid", q_valid, 1'b1);
    pop();

    // XOR len=0 is treated as one sample.
    send(2'b10, 4'd0, {4'b0011, 4'b0101});
    check("xor0_qvalid", q_valid, 1'b1);
    check("xor0_q", Q, 4'b0110);
    check("xor0_count", count, 1);

    // Input offered in DONE with q_ready in the same cycle: taken only next cycle.
    mode = 2'b00; len = 4'd1; A = 8'hFF; in_valid = 1'b1; q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    check("done_noaccept_qvalid", q_valid, 1'b0);
    check("done_noaccept_count", count, 0);
    check("done_noaccept_q", Q, 4'b0110);
    tick();
    in_valid = 1'b0;
    check("done_next_qvalid", q_valid, 1'b1);
    check("done_next_q", Q, 4'b1111);
    pop();

    // Reset mid-transaction abandons it.
    send(2'b01, 4'd3, {4'b0000, 4'b0001});
    check("abandon_count1", count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abandon_qvalid", q_valid, 1'b0);
    check("abandon_count", count, 0);
    check("abandon_inready", in_ready, 1'b1);
    check("abandon_q", Q, 4'b0000);
    send(2'b00, 4'd1, {4'b0110, 4'b0011});
    check("after_rst_q", Q, 4'b0010);
    check("after_rst_qvalid", q_valid, 1'b1);
    pop();

    // Reset wins over a same-cycle accept.
    mode = 2'b01; len = 4'd1; A = 8'hFF; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_over_accept_qvalid", q_valid, 1'b0);
    check("rst_over_accept_count", count, 0);

    // Table of single-sample transactions.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].mode, 4'd1, vecs[i].a);
      check("vec_qvalid", q_valid, 1'b1);
      check($sformatf("vec%0d_q", i), Q, vecs[i].exp_q);
      pop();
    end

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] m;
      logic [3:0] l;
      int         tgt;
      logic [7:0] samples[$];
      logic [3:0] exp_q;
      m   = 2'($urandom_range(0, 3));
      l   = (t % 10 == 9) ? 4'd15 : 4'($urandom_range(0, 6));
      tgt = (l == 0) ? 1 : int'(l);
      samples = {};
      for (int s = 0; s < tgt; s++) samples.push_back(8'($urandom));
      exp_q = ref_result(m, samples);
      for (int s = 0; s < tgt; s++) begin
        q_ready = 1'($urandom);
        // Later samples carry junk mode/len that must be ignored.
        if (s == 0) send(m, l, samples[s]);
        else        send(2'($urandom), 4'($urandom), samples[s]);
        q_ready = 1'b0;
        if (s < tgt - 1) begin
          check("rnd_count", count, s + 1);
          check("rnd_busy_qvalid", q_valid, 1'b0);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      check("rnd_qvalid", q_valid, 1'b1);
      check($sformatf("rnd%0d_q", t), Q, exp_q);
      check("rnd_final_count", count, tgt);
      q_hold = Q;
      repeat ($urandom_range(0, 3)) tick();
      check("rnd_hold_q", Q, q_hold);
      pop();
      check("rnd_pop_qvalid", q_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_accum.md
GATE_ACCUM -- requirements
Module: gate_accum

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 8, bit width of each operand channel and of Q.
REQ-003 Parameter NCH, default 2, number of operand channels (>=1).
REQ-004 Parameter LEN_W, default 4, width of len and count.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 mode  in  2  00 AND, 01 OR, 10 XOR, 11 NAND; sampled on first accepted sample only.
REQ-008 len  in  LEN_W  samples per result; sampled on first accepted sample only.
REQ-009 in_valid  in  1  A valid this cycle.
REQ-010 in_ready  out  1  block accepts A this cycle.
REQ-011 A  in  NCH*WIDTH  operand channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-012 Q  out  WIDTH  registered result.
REQ-013 q_valid  out  1  Q holds a finished result.
REQ-014 q_ready  in  1  consumer takes Q.
REQ-015 count  out  LEN_W  samples accepted in current transaction.

Function
REQ-016 Sample accepted iff in_valid && in_ready at the clock edge.
REQ-017 Per sample: f = bitwise reduction across all NCH channels using base op (AND for AND/NAND, OR, XOR); NCH=1 gives f = channel 0.
REQ-018 States IDLE, ACCUM, DONE; in_ready=1 in IDLE and ACCUM, 0 in DONE; q_valid=1 only in DONE.
REQ-019 IDLE accept: latch mode, target = (len==0 ? 1 : len), acc<=f, count<=1; go DONE if target==1, else ACCUM.
REQ-020 ACCUM accept: acc <= acc base-op f, count<=count+1; go DONE when count+1==target; no accept = hold.
REQ-021 Q = acc, inverted bitwise when latched mode is NAND; registered, stable throughout DONE.
REQ-022 Latency: q_valid rises the cycle after the final sample is accepted.
REQ-023 DONE: on q_ready go IDLE, count<=0; Q retains its value in IDLE until overwritten.
REQ-024 in_valid in DONE (including same cycle as q_ready) SHALL NOT be accepted; it is accepted the following IDLE cycle if still asserted.
REQ-025 q_ready outside DONE ignored; mode/len changes after first sample ignored.
REQ-026 Maximum target 2^LEN_W-1; count never wraps within a transaction.

Reset
REQ-027 rst SHALL force state IDLE, acc=0, Q=0, q_valid=0, count=0, target=1, latched mode=AND; in_ready=1 the cycle after rst deasserts.
REQ-028 rst asserted in ACCUM or DONE SHALL abandon the transaction with no result produced; rst overrides any same-cycle accept.

Structure
REQ-029 Package gate_pkg SHALL hold the mode enum (MODE_AND, MODE_OR, MODE_XOR, MODE_NAND) and the state enum (ST_IDLE, ST_ACCUM, ST_DONE).
REQ-030 Combinational NCH-way reduction SHALL be sub-module gate_reduce (params WIDTH, NCH; inputs op, A; output f); FSM, counter and accumulator in gate_accum.

Verification (WIDTH=4, NCH=2, LEN_W=4; A written {ch1,ch0})
REQ-031 rst=1 two cycles -> Q=0000, q_valid=0, in_ready=1, count=0.
REQ-032 AND, len=1, A={1100,1010} -> next cycle q_valid=1, Q=1000, count=1; q_ready held low 5 cycles -> Q stable, in_ready=0; q_ready=1 -> IDLE, count=0.
REQ-033 OR, len=3, samples {0000,0001},{0000,0010},{1000,0000} with one idle cycle between -> Q=1011, count=3 after third.
REQ-034 NAND, len=2, samples {1110,1111},{0111,1111} -> Q=1001; XOR, len=0, A={0011,0101} -> treated as 1, Q=0110.
REQ-035 in_valid=1 with A={1111,1111} while in DONE and q_ready=1 same cycle -> sample not taken that cycle, accepted next IDLE cycle.
REQ-036 OR, len=3, rst after first sample -> q_valid=0, count=0, IDLE; new AND len=1 {0110,0011} -> Q=0010.
